cw_sequencer: RTL
=================

Name: cw_sequencer

Overview:
- Parametrised control-word sequencer. Stores a short program of (control word, constant, hold count) entries and plays them into the LEGv8 datapath's ControlWord/constant inputs, one entry per step.
- Replaces hand-timed delay sequences with a deterministic, reloadable, loopable stimulus source.
- Usable in benches and as a microcode front-end for the datapath.

Parameters:
- CW_WIDTH, 40, control word width.
- CONST_WIDTH, 64, constant width.
- DEPTH, 16, program entries (power of two, >=2).
- HOLD_W, 4, hold counter width; an entry is driven for hold+1 cycles.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- load_en  in  1  write program entry.
- load_addr  in  clog2(DEPTH)  entry index.
- load_cw  in  CW_WIDTH  control word.
- load_const  in  CONST_WIDTH  constant.
- load_hold  in  HOLD_W  extra hold cycles.
- load_last  in  1  marks end of program.
- start  in  1  begin playback at entry 0.
- abort  in  1  stop playback immediately.
- loop_en  in  1  wrap to entry 0 after last entry.
- step_mode  in  1  pause after each entry.
- step  in  1  advance one entry while paused.
- ControlWord  out  CW_WIDTH  registered control word to datapath.
- constant  out  CONST_WIDTH  registered constant to datapath.
- step_idx  out  clog2(DEPTH)  index of entry being driven.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  program completed.

Behaviour:
- Reset (synchronous, active-high):
  - State IDLE.
  - ControlWord=0, constant=0, step_idx=0, busy=0, done=0, hold counter=0.
  - Program memory is not cleared.
- States: IDLE, RUN, PAUSE, DONE.
- Idle output: ControlWord=0 (NOP) in IDLE and DONE; constant holds its last value.
- Load:
  - Accepted only in IDLE or DONE; ignored in RUN/PAUSE.
  - Writes take effect next cycle.
  - Load is ignored in a cycle where start=1.
- Start:
  - start in IDLE/DONE -> next edge: RUN, step_idx=0, ControlWord=mem[0].cw, constant=mem[0].const, counter=mem[0].hold, done=0.
  - Latency is 1 cycle.
  - start in RUN/PAUSE is ignored.
- RUN:
  - Counter nonzero: decrement; outputs stable.
  - Counter zero, entry not terminal: if step_mode, go to PAUSE (outputs held); else load entry step_idx+1 on the next edge.
- Terminal entry: load_last=1, or step_idx=DEPTH-1 (wrap guard).
  - loop_en=1: next entry is 0, stay in RUN, no bubble cycle.
  - loop_en=0: DONE, ControlWord=0, done=1.
- PAUSE:
  - step=1 -> load the next entry per the same terminal/loop rules, return to RUN.
  - step_mode deasserted while in PAUSE also advances.
- DONE: done stays high until start or reset.
- abort:
  - In RUN/PAUSE -> next edge IDLE, ControlWord=0, busy=0, done=0.
  - abort has priority over step, loop and start.
- reset mid-playback behaves as abort, and additionally zeroes constant and step_idx.
- Width rule: hold is unsigned; hold=0 means one cycle; max HOLD=2^HOLD_W cycles.

Decomposition:
- Package cw_seq_pkg:
  - State enum (IDLE/RUN/PAUSE/DONE).
  - Entry struct {cw, const, hold, last}.
  - NOP_CW constant = 0.
- One sub-module: cw_seq_mem.
  - Synchronous-write, asynchronous-read DEPTH-entry array of the entry struct.
- Top: FSM, hold counter, output registers.

Test Plan:
- Single step: load entry0 {cw=40'h0_0008_C0F80, const=24, hold=0, last=1}, pulse start -> next cycle ControlWord=40'h0_0008_C0F80, constant=24, busy=1; one cycle later ControlWord=0, done=1.
- Hold timing: entries {A,hold=2},{B,hold=0,last} -> A driven exactly 3 cycles, B 1 cycle, then DONE; step_idx goes 0,0,0,1.
- Loop: same program with loop_en=1 -> pattern A,A,A,B repeats with no NOP gap for 3 iterations; abort -> next cycle ControlWord=0, busy=0, done=0.
- Step mode: 3 entries, step_mode=1 -> after each entry's hold, outputs stay frozen in PAUSE for 5 cycles until a step pulse; next entry appears one cycle after step.
- Guards:
  - load_en during RUN leaves mem unchanged (verify after DONE by replay).
  - start during RUN has no effect.
  - Program with no last flag stops at entry 15.
- Reset mid-run: assert reset at entry 2 -> next edge all outputs 0, IDLE; then start replays from entry 0 with program intact.

Source files
------------

// File: rtl/cw_seq_pkg.sv
// rtl/cw_seq_pkg.sv - shared types for the control-word sequencer
//
// Purpose: FSM state encoding, program-entry layout and the NOP control word
// shared by cw_sequencer and its program memory.
// Ports:   none (package).
package cw_seq_pkg;

  // Entry field widths. These bound the widest configuration of the
  // sequencer; narrower instances zero-extend into the entry on write and
  // truncate on read.
  localparam int unsigned ENTRY_CW_W    = 40;
  localparam int unsigned ENTRY_CONST_W = 64;
  localparam int unsigned ENTRY_HOLD_W  = 4;

  // Control word driven whenever no entry is being played.
  localparam logic [ENTRY_CW_W-1:0] NOP_CW = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [ENTRY_CW_W-1:0]    cw;
    logic [ENTRY_CONST_W-1:0] cnst;
    logic [ENTRY_HOLD_W-1:0]  hold;
    logic                     last;
  } entry_t;

  // Program memory may only be rewritten and playback (re)started from here.
  function automatic logic is_quiescent(input state_e s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/cw_seq_mem.sv
// rtl/cw_seq_mem.sv - program memory for the control-word sequencer
//
// Purpose: DEPTH-entry store of program entries; synchronous write,
//          asynchronous read. Contents are never cleared by reset.
// Ports:
//   clk_i    - rising-edge clock
//   we_i     - write enable
//   waddr_i  - write entry index
//   wdata_i  - entry to write
//   raddr_i  - read entry index
//   rdata_o  - entry at raddr_i (combinational)
module cw_seq_mem
  import cw_seq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  entry_t                   wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output entry_t                   rdata_o
);

  entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cw_sequencer.sv
// rtl/cw_sequencer.sv - loopable control-word/constant sequencer for the datapath
//
// Purpose: plays a stored program of (control word, constant, hold) entries
//          into the datapath, one entry per step, each held for hold+1 cycles.
//          Supports single-shot, looping and single-step playback.
// Ports:
//   clock, reset              - rising-edge clock, synchronous active-high reset
//   load_en/addr/cw/const/hold/last - program entry write (IDLE/DONE only)
//   start, abort              - begin playback at entry 0 / stop immediately
//   loop_en                   - wrap to entry 0 after the terminal entry
//   step_mode, step           - pause after each entry / advance while paused
//   ControlWord, constant     - registered outputs to the datapath
//   step_idx                  - index of the entry being driven
//   busy, done                - playing (RUN/PAUSE) / program completed
module cw_sequencer
  import cw_seq_pkg::*;
#(
  parameter int CW_WIDTH    = 40,
  parameter int CONST_WIDTH = 64,
  parameter int DEPTH       = 16,
  parameter int HOLD_W      = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [CW_WIDTH-1:0]      load_cw,
  input  logic [CONST_WIDTH-1:0]   load_const,
  input  logic [HOLD_W-1:0]        load_hold,
  input  logic                     load_last,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     loop_en,
  input  logic                     step_mode,
  input  logic                     step,
  output logic [CW_WIDTH-1:0]      ControlWord,
  output logic [CONST_WIDTH-1:0]   constant,
  output logic [$clog2(DEPTH)-1:0] step_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e                 state_q;
  logic [CW_WIDTH-1:0]    cw_q;
  logic [CONST_WIDTH-1:0] const_q;
  logic [AW-1:0]          idx_q;
  logic [HOLD_W-1:0]      hold_q;
  logic                   last_q;
  logic                   busy_q;
  logic                   done_q;

  logic                   quiescent;
  logic                   terminal;
  logic                   wr_en;
  entry_t                 wr_entry;
  logic [AW-1:0]          rd_addr_d;
  entry_t                 rd_entry;

  // Actions decided this cycle; the FSM register block applies them.
  logic act_abort;
  logic act_load;
  logic act_finish;
  logic act_pause;
  logic act_count;

  assign quiescent = is_quiescent(state_q);

  // The current entry's last flag is captured when it is loaded, so the
  // single read port is always free to fetch the entry that comes next.
  assign terminal = last_q || (idx_q == LAST_IDX);

  // Entry 0 follows a start or a terminal entry (loop wrap); otherwise idx+1.
  assign rd_addr_d = (quiescent || terminal) ? '0 : idx_q + AW'(1);

  // A start in the same cycle wins over a program write.
  assign wr_en = load_en && quiescent && !start;

  always_comb begin
    wr_entry      = '0;
    wr_entry.cw   = ENTRY_CW_W'(load_cw);
    wr_entry.cnst = ENTRY_CONST_W'(load_const);
    wr_entry.hold = ENTRY_HOLD_W'(load_hold);
    wr_entry.last = load_last;
  end

  cw_seq_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clock),
    .we_i    (wr_en),
    .waddr_i (load_addr),
    .wdata_i (wr_entry),
    .raddr_i (rd_addr_d),
    .rdata_o (rd_entry)
  );

  always_comb begin
    act_abort  = 1'b0;
    act_load   = 1'b0;
    act_finish = 1'b0;
    act_pause  = 1'b0;
    act_count  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        act_load = start;
      end
      ST_RUN: begin
        if (abort) begin
          act_abort = 1'b1;
        end else if (hold_q != '0) begin
          act_count = 1'b1;
        end else if (terminal) begin
          // Looping reloads entry 0 directly: no NOP bubble between passes.
          act_load   = loop_en;
          act_finish = !loop_en;
        end else if (step_mode) begin
          act_pause = 1'b1;
        end else begin
          act_load = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (abort) begin
          act_abort = 1'b1;
        end else if (step || !step_mode) begin
          act_load   = !terminal || loop_en;
          act_finish = terminal && !loop_en;
        end
      end
      default: begin
        act_abort = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cw_q    <= '0;
      const_q <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (act_abort) begin
      // constant and step_idx deliberately keep their last values.
      state_q <= ST_IDLE;
      cw_q    <= CW_WIDTH'(NOP_CW);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (act_load) begin
      state_q <= ST_RUN;
      cw_q    <= CW_WIDTH'(rd_entry.cw);
      const_q <= CONST_WIDTH'(rd_entry.cnst);
      hold_q  <= HOLD_W'(rd_entry.hold);
      last_q  <= rd_entry.last;
      idx_q   <= rd_addr_d;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else if (act_finish) begin
      state_q <= ST_DONE;
      cw_q    <= CW_WIDTH'(NOP_CW);
      busy_q  <= 1'b0;
      done_q  <= 1'b1;
    end else if (act_pause) begin
      state_q <= ST_PAUSE;
    end else if (act_count) begin
      hold_q <= hold_q - HOLD_W'(1);
    end
  end

  assign ControlWord = cw_q;
  assign constant    = const_q;
  assign step_idx    = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
